adc_acq_mc: RTL and testbench

ADC_ACQ_MC -- requirements
Module: adc_acq_mc

---
 rtl/adc_pkg.sv | 20 ++
 rtl/si_fifo.sv | 78 +++++++
 rtl/adc_acq_mc.sv | 166 ++++++++++++++++
 tb/tb_adc_acq_mc.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the multi-channel ADC acquisition block.
package adc_pkg;

    // Per-window reduction applied to every channel
    typedef enum logic [1:0] {
        MODE_SAMPLE   = 2'd0,
        MODE_AVERAGE  = 2'd1,
        MODE_PEAK_MAX = 2'd2,
        MODE_PEAK_MIN = 2'd3
    } acq_mode_e;

    // Headroom for summing up to 2^7 samples without wrapping
    localparam int ACC_EXTRA_BITS = 7;
    localparam int MAX_WIN_LOG2   = 7;

    function automatic int acc_width(input int data_width);
        return data_width + ACC_EXTRA_BITS;
    endfunction

endpackage

// File: rtl/si_fifo.sv
// Synchronous output FIFO with a ready/acknowledge pop and a registered head word.
module si_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_ack,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_rdy,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    rd_ptr_r, wr_ptr_r, rd_ptr_n_s;
    logic [AW:0]      count_r, count_n_s;
    logic [WIDTH-1:0] rd_data_r, head_n_s;
    logic             rdy_r, pop_s, push_s;

    // Pop only a word the consumer can see; a full FIFO still accepts a write when it is popped
    always_comb begin
        pop_s      = rdy_r && rd_ack;
        push_s     = wr_en && ((count_r != FULL_CNT) || pop_s);
        rd_ptr_n_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        if (push_s && !pop_s) begin
            count_n_s = count_r + (AW+1)'(1);
        end else if (pop_s && !push_s) begin
            count_n_s = count_r - (AW+1)'(1);
        end else begin
            count_n_s = count_r;
        end
        // A write landing in the slot that becomes head bypasses the memory
        if (push_s && (wr_ptr_r == rd_ptr_n_s)) begin
            head_n_s = wr_data;
        end else begin
            head_n_s = mem_r[rd_ptr_n_s];
        end
    end

    // Pointer, occupancy and registered head-word state
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            rd_ptr_r  <= {AW{1'b0}};
            wr_ptr_r  <= {AW{1'b0}};
            count_r   <= {(AW+1){1'b0}};
            rd_data_r <= {WIDTH{1'b0}};
            rdy_r     <= 1'b0;
        end else begin
            rd_ptr_r <= rd_ptr_n_s;
            wr_ptr_r <= push_s ? (wr_ptr_r + AW'(1)) : wr_ptr_r;
            count_r  <= count_n_s;
            rdy_r    <= (count_n_s != {(AW+1){1'b0}});
            if (count_n_s != {(AW+1){1'b0}}) begin
                rd_data_r <= head_n_s;
            end
        end
    end

    // Storage array; contents are only meaningful between the pointers
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = rd_data_r;
    assign rd_rdy  = rdy_r;
    assign full    = (count_r == FULL_CNT);
    assign empty   = (count_r == {(AW+1){1'b0}});
    assign count   = count_r;

endmodule

// File: rtl/adc_acq_mc.sv
// Multi-channel ADC acquisition: clock divider, per-window reduction, output FIFO.
module adc_acq_mc
    import adc_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int NUM_CH        = 2,
    parameter int CLK_DIV_WIDTH = 32,
    parameter int FIFO_DEPTH    = 4
) (
    input  logic                         clk_i,
    input  logic                         rst,
    input  logic [NUM_CH*DATA_WIDTH-1:0] ADC_data,
    output logic                         ADC_oe,
    output logic                         clk_o,
    output logic [NUM_CH*DATA_WIDTH-1:0] SI_data,
    output logic                         SI_rdy,
    input  logic                         SI_ack,
    input  logic [CLK_DIV_WIDTH-1:0]     decimation_factor,
    input  logic [1:0]                   mode,
    input  logic [2:0]                   win_log2,
    input  logic                         enable,
    output logic                         overflow,
    input  logic                         overflow_clr
);
    localparam int ACC_W  = acc_width(DATA_WIDTH);
    localparam int TCW    = MAX_WIN_LOG2 + 1;
    localparam int WORD_W = NUM_CH * DATA_WIDTH;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic [CLK_DIV_WIDTH-1:0] div_cnt_r;
    logic                     clk_div_r, div_zero_s, terminal_s, tick_s;
    logic [1:0]               mode_q_r;
    logic [2:0]               win_q_r;
    logic [TCW-1:0]           tick_cnt_r, tick_base_s, win_last_s;
    logic                     cfg_chg_s, first_s, done_s;
    logic [ACC_W-1:0]         acc_r [NUM_CH];
    logic [ACC_W-1:0]         acc_n_s [NUM_CH];
    logic [ACC_W-1:0]         samp_s [NUM_CH];
    logic [ACC_W-1:0]         avg_s [NUM_CH];
    logic [WORD_W-1:0]        result_s, result_r;
    logic                     res_vld_r, overflow_r;
    logic                     fifo_full_s, fifo_empty_s, pop_s, drop_s;
    logic [CNT_W-1:0]         fifo_count_s;

    assign ADC_oe     = 1'b0;
    assign div_zero_s = (decimation_factor == {CLK_DIV_WIDTH{1'b0}});
    // >= so that shrinking D below the running count terminates instead of wrapping
    assign terminal_s = (div_cnt_r >= (decimation_factor - CLK_DIV_WIDTH'(1)));
    assign clk_o      = div_zero_s ? clk_i : clk_div_r;

    // Sampling strobe: every cycle undivided, else on the rising edge of the divided clock
    always_comb begin
        if (div_zero_s) begin
            tick_s = 1'b1;
        end else begin
            tick_s = terminal_s && !clk_div_r;
        end
    end

    // Free-running divider, independent of acquisition enable
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            div_cnt_r <= {CLK_DIV_WIDTH{1'b0}};
            clk_div_r <= 1'b0;
        end else if (div_zero_s) begin
            div_cnt_r <= {CLK_DIV_WIDTH{1'b0}};
            clk_div_r <= 1'b0;
        end else if (terminal_s) begin
            div_cnt_r <= {CLK_DIV_WIDTH{1'b0}};
            clk_div_r <= ~clk_div_r;
        end else begin
            div_cnt_r <= div_cnt_r + CLK_DIV_WIDTH'(1);
        end
    end

    // Per-channel reduction; a config change makes the current tick the first of a new window
    always_comb begin
        cfg_chg_s   = (mode != mode_q_r) || (win_log2 != win_q_r);
        tick_base_s = cfg_chg_s ? {TCW{1'b0}} : tick_cnt_r;
        first_s     = (tick_base_s == {TCW{1'b0}});
        if (acq_mode_e'(mode) == MODE_SAMPLE) begin
            win_last_s = {TCW{1'b0}};
        end else begin
            win_last_s = (TCW'(1) << win_log2) - TCW'(1);
        end
        done_s   = enable && tick_s && (tick_base_s == win_last_s);
        result_s = {WORD_W{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            samp_s[k] = ACC_W'(ADC_data[k*DATA_WIDTH +: DATA_WIDTH]);
            case (acq_mode_e'(mode))
                MODE_SAMPLE:   acc_n_s[k] = samp_s[k];
                MODE_AVERAGE:  acc_n_s[k] = (first_s ? {ACC_W{1'b0}} : acc_r[k]) + samp_s[k];
                MODE_PEAK_MAX: acc_n_s[k] = (first_s || (samp_s[k] > acc_r[k])) ? samp_s[k] : acc_r[k];
                MODE_PEAK_MIN: acc_n_s[k] = (first_s || (samp_s[k] < acc_r[k])) ? samp_s[k] : acc_r[k];
                default:       acc_n_s[k] = acc_r[k];
            endcase
            avg_s[k] = acc_n_s[k] >> win_log2;
            if (acq_mode_e'(mode) == MODE_AVERAGE) begin
                result_s[k*DATA_WIDTH +: DATA_WIDTH] = avg_s[k][DATA_WIDTH-1:0];
            end else begin
                result_s[k*DATA_WIDTH +: DATA_WIDTH] = acc_n_s[k][DATA_WIDTH-1:0];
            end
        end
    end

    // Window bookkeeping and result register feeding the FIFO one edge later
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= {TCW{1'b0}};
            mode_q_r   <= 2'd0;
            win_q_r    <= 3'd0;
            result_r   <= {WORD_W{1'b0}};
            res_vld_r  <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) acc_r[k] <= {ACC_W{1'b0}};
        end else begin
            mode_q_r  <= mode;
            win_q_r   <= win_log2;
            res_vld_r <= done_s;
            if (done_s) result_r <= result_s;
            if (!enable || done_s || (cfg_chg_s && !tick_s)) begin
                tick_cnt_r <= {TCW{1'b0}};
                for (int k = 0; k < NUM_CH; k++) acc_r[k] <= {ACC_W{1'b0}};
            end else if (tick_s) begin
                tick_cnt_r <= tick_base_s + TCW'(1);
                for (int k = 0; k < NUM_CH; k++) acc_r[k] <= acc_n_s[k];
            end
        end
    end

    // A write is lost only if the FIFO is full and not being popped; either fullness view counts
    always_comb begin
        pop_s  = SI_ack && SI_rdy && !fifo_empty_s;
        drop_s = res_vld_r && !pop_s && (fifo_full_s || (fifo_count_s >= FULL_CNT));
    end

    // Sticky overflow; a new drop outranks a clear on the same edge
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (overflow_clr) begin
            overflow_r <= 1'b0;
        end
    end

    assign overflow = overflow_r;

    si_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_si_fifo (
        .clk_i   (clk_i),
        .rst     (rst),
        .wr_en   (res_vld_r),
        .wr_data (result_r),
        .rd_ack  (SI_ack),
        .rd_data (SI_data),
        .rd_rdy  (SI_rdy),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (fifo_count_s)
    );

endmodule

// File: tb/tb_adc_acq_mc.sv
// Self-checking bench for adc_acq_mc with a window-level reference model.
module tb_adc_acq_mc;
    localparam int DW = 8, NCH = 2, CDW = 32, DEPTH = 4, WW = NCH * DW;

    logic           clk_i = 1'b0;
    logic           rst = 1'b1;
    logic [WW-1:0]  ADC_data = '0;
    logic           ADC_oe, clk_o, SI_rdy, overflow;
    logic [WW-1:0]  SI_data;
    logic           SI_ack = 1'b0;
    logic [CDW-1:0] decimation_factor = '0;
    logic [1:0]     mode = 2'd0;
    logic [2:0]     win_log2 = 3'd0;
    logic           enable = 1'b0;
    logic           overflow_clr = 1'b0;

    int total = 0;
    int bad = 0;
    logic [WW-1:0] stim [0:255];

    adc_acq_mc #(.DATA_WIDTH(DW), .NUM_CH(NCH), .CLK_DIV_WIDTH(CDW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst(rst), .ADC_data(ADC_data), .ADC_oe(ADC_oe), .clk_o(clk_o),
        .SI_data(SI_data), .SI_rdy(SI_rdy), .SI_ack(SI_ack),
        .decimation_factor(decimation_factor), .mode(mode), .win_log2(win_log2),
        .enable(enable), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Window m of stim reduced per channel with plain arithmetic
    function automatic logic [WW-1:0] model_word(input int md, input int wl, input int m);
        logic [WW-1:0] r;
        int w, v, sum, mx, mn;
        r = '0;
        w = (md == 0) ? 1 : (1 << wl);
        for (int ch = 0; ch < NCH; ch++) begin
            sum = 0; mx = 0; mn = 255; v = 0;
            for (int j = 0; j < w; j++) begin
                v = int'(stim[m*w + j][ch*DW +: DW]);
                sum += v;
                if (v > mx) mx = v;
                if (v < mn) mn = v;
            end
            case (md)
                0: r[ch*DW +: DW] = DW'(v);
                1: r[ch*DW +: DW] = DW'(sum >> wl);
                2: r[ch*DW +: DW] = DW'(mx);
                default: r[ch*DW +: DW] = DW'(mn);
            endcase
        end
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++; if (SI_rdy !== 1'b0) begin bad++; $display("FAIL rst_rdy: got %b want 0", SI_rdy); end
        total++; if (SI_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", SI_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", overflow); end
        total++; if (ADC_oe !== 1'b0) begin bad++; $display("FAIL adc_oe: got %b want 0", ADC_oe); end
    endtask

    // Runs nwin windows from stim with SI_ack held high; ticks land where edge n % 2D == D
    task automatic run_windows(input int d, input int md, input int wl, input int nwin);
        int w, nt, t, n;
        int ce_q[$];
        logic [WW-1:0] word_q[$];
        logic exp_clk;
        w  = (md == 0) ? 1 : (1 << wl);
        nt = nwin * w;
        decimation_factor = CDW'(d); mode = 2'(md); win_log2 = 3'(wl);
        enable = 1'b1; SI_ack = 1'b1; overflow_clr = 1'b0; ADC_data = stim[0];
        rst = 1'b1;
        step();
        rst = 1'b0;
        total++; if (SI_rdy !== 1'b0) begin bad++; $display("FAIL win_start_rdy d=%0d m=%0d: got %b want 0", d, md, SI_rdy); end
        if (d == 0) begin
            @(negedge clk_i); #1;
            total++; if (clk_o !== 1'b0) begin bad++; $display("FAIL clk_o_low: got %b want 0", clk_o); end
        end
        t = 0; n = 0;
        while ((t < nt || ce_q.size() > 0) && n < 2000) begin
            if (t < nt) ADC_data = stim[t];
            step();
            n++;
            if (ce_q.size() > 0 && n == ce_q[0] + 1) begin
                total++;
                if (SI_rdy !== 1'b1 || SI_data !== word_q[0]) begin
                    bad++;
                    $display("FAIL win_word d=%0d m=%0d wl=%0d edge=%0d: got rdy=%b data=%h want rdy=1 data=%h",
                             d, md, wl, n, SI_rdy, SI_data, word_q[0]);
                end
                void'(ce_q.pop_front());
                void'(word_q.pop_front());
            end
            if (t < nt && (d == 0 || (n % (2*d)) == d)) begin
                t++;
                if (t % w == 0) begin
                    ce_q.push_back(n);
                    word_q.push_back(model_word(md, wl, t/w - 1));
                end
                if (t == nt) enable = 1'b0;
            end
            exp_clk = (d == 0) ? 1'b1 : (((n / d) % 2) == 1);
            total++;
            if (clk_o !== exp_clk) begin
                bad++; $display("FAIL clk_o d=%0d edge=%0d: got %b want %b", d, n, clk_o, exp_clk);
            end
        end
        if (n >= 2000) begin
            bad++; $display("FAIL win_timeout d=%0d m=%0d: got %0d pending want 0", d, md, ce_q.size());
        end
    endtask

    task automatic test_overflow();
        logic [WW-1:0] v [6];
        decimation_factor = '0; mode = 2'd0; win_log2 = 3'd0; enable = 1'b0; SI_ack = 1'b0; overflow_clr = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            v[i] = WW'($urandom);
            ADC_data = v[i];
            enable = 1'b1;
            step();
        end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b want 1", overflow); end
        enable = 1'b0;
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set_wins: got %b want 1", overflow); end
        step();
        for (int k = 0; k < DEPTH; k++) begin
            total++;
            if (SI_rdy !== 1'b1 || SI_data !== v[k]) begin
                bad++; $display("FAIL ovf_drain%0d: got rdy=%b data=%h want rdy=1 data=%h", k, SI_rdy, SI_data, v[k]);
            end
            SI_ack = 1'b1;
            step();
        end
        SI_ack = 1'b0;
        total++; if (SI_rdy !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %b want 0", SI_rdy); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b want 0", overflow); end
    endtask

    task automatic test_div_change();
        logic [WW-1:0] v;
        logic exp_clk;
        v = WW'($urandom);
        decimation_factor = CDW'(100); mode = 2'd0; win_log2 = 3'd0;
        enable = 1'b1; SI_ack = 1'b1; overflow_clr = 1'b0; ADC_data = v;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 50; i++) step();
        total++; if (clk_o !== 1'b0 || SI_rdy !== 1'b0) begin bad++; $display("FAIL div_pre: got clk_o=%b rdy=%b want 0 0", clk_o, SI_rdy); end
        decimation_factor = CDW'(2);
        step();
        total++; if (clk_o !== 1'b1 || SI_rdy !== 1'b0) begin bad++; $display("FAIL div_term: got clk_o=%b rdy=%b want 1 0", clk_o, SI_rdy); end
        step();
        total++; if (SI_rdy !== 1'b1 || SI_data !== v) begin bad++; $display("FAIL div_word: got rdy=%b data=%h want rdy=1 data=%h", SI_rdy, SI_data, v); end
        for (int k = 2; k < 12; k++) begin
            step();
            exp_clk = (((k / 2) % 2) == 0);
            total++;
            if (clk_o !== exp_clk) begin bad++; $display("FAIL div_period k=%0d: got %b want %b", k, clk_o, exp_clk); end
        end
    endtask

    task automatic test_reset_mid();
        decimation_factor = '0; mode = 2'd0; win_log2 = 3'd0; enable = 1'b0; SI_ack = 1'b0; overflow_clr = 1'b0;
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ADC_data = WW'($urandom);
            enable = 1'b1;
            step();
        end
        enable = 1'b0;
        step(); step();
        total++; if (SI_rdy !== 1'b1 || overflow !== 1'b1) begin bad++; $display("FAIL mid_pre: got rdy=%b ovf=%b want 1 1", SI_rdy, overflow); end
        mode = 2'd1; win_log2 = 3'd2; enable = 1'b1;
        ADC_data = {WW{1'b1}};
        step(); step();
        #3;
        rst = 1'b1;
        #1;
        total++; if (SI_rdy !== 1'b0) begin bad++; $display("FAIL mid_rdy: got %b want 0", SI_rdy); end
        total++; if (SI_data !== '0) begin bad++; $display("FAIL mid_data: got %h want 0", SI_data); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_ovf: got %b want 0", overflow); end
        for (int i = 0; i < 256; i++) stim[i] = WW'($urandom);
        run_windows(0, 1, 2, 2);
    endtask

    initial begin
        test_reset();
        // Undivided sample stream: a ramp with a random offset per channel
        for (int i = 0; i < 256; i++) stim[i] = {DW'(i * 3 + 7), DW'(i + ($urandom % 16))};
        run_windows(0, 0, 0, 20);
        // D=3 average of 10,20,30,41 on ch0
        for (int i = 0; i < 256; i++) stim[i] = WW'($urandom);
        stim[0][7:0] = 8'd10; stim[1][7:0] = 8'd20; stim[2][7:0] = 8'd30; stim[3][7:0] = 8'd41;
        run_windows(3, 1, 2, 1);
        // Peaks of 5,200,7,9 on both channels
        stim[0] = {8'd5, 8'd5}; stim[1] = {8'd200, 8'd200}; stim[2] = {8'd7, 8'd7}; stim[3] = {8'd9, 8'd9};
        run_windows(1, 2, 2, 1);
        run_windows(1, 3, 2, 1);
        for (int i = 0; i < 256; i++) stim[i] = WW'($urandom);
        run_windows(2, 1, 3, 2);
        run_windows(0, 1, 7, 1);
        run_windows(0, 3, 0, 5);
        run_windows(1, 2, 1, 3);
        test_overflow();
        test_div_change();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
